// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the EX-stage M-extension units.
package cpu_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam logic [6:0]  FUNCT7_MULDIV = 7'h01;
  localparam logic [31:0] DIV_ZERO_Q    = '1;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_EX,
  input  logic [1:0]      op_EX,
  input  logic [XLEN-1:0] rs1_EX,
  input  logic [XLEN-1:0] rs2_EX,
  input  logic            flush_EX,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN-1);

  div_state_t       state;
  div_op_t          op;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic             sgn_in;
  logic             sgn_op;
  logic [XLEN-1:0]  abs1;
  logic [XLEN-1:0]  abs2;
  logic [XLEN:0]    trial;

  // trial is one bit wider so its MSB is the borrow of the restoring step
  always_comb begin
    sgn_in = (op_EX == DIV) || (op_EX == REM);
    sgn_op = (op == DIV) || (op == REM);
    abs1   = (sgn_in && rs1_EX[XLEN-1]) ? ('0 - rs1_EX) : rs1_EX;
    abs2   = (sgn_in && rs2_EX[XLEN-1]) ? ('0 - rs2_EX) : rs2_EX;
    trial  = {rem, quo[XLEN-1]} - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= DIV;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_EX && !flush_EX) begin
            op   <= div_op_t'(op_EX);
            busy <= 1'b1;
            if (rs2_EX == '0) begin
              quo   <= '1;
              rem   <= rs1_EX;
              state <= DONE;
            end else if (sgn_in && rs1_EX == MIN_NEG && rs2_EX == '1) begin
              quo   <= MIN_NEG;
              rem   <= '0;
              state <= DONE;
            end else begin
              quo   <= abs1;
              rem   <= '0;
              dvs   <= abs2;
              neg_q <= sgn_in && (rs1_EX[XLEN-1] ^ rs2_EX[XLEN-1]);
              neg_r <= sgn_in && rs1_EX[XLEN-1];
              cnt   <= '0;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (flush_EX) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= {rem[XLEN-2:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= FIX;
          end
        end

        FIX: begin
          if (flush_EX) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (sgn_op && neg_q) quo <= '0 - quo;
            if (sgn_op && neg_r) rem <= '0 - rem;
            state <= DONE;
          end
        end

        DONE: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= (op == REM || op == REMU) ? rem : quo;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected results, monitor checks each done pulse.
module tb_div_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_EX = 1'b0;
  logic        flush_EX = 1'b0;
  logic [1:0]  op_EX = 2'b00;
  logic [31:0] rs1_EX = '0;
  logic [31:0] rs2_EX = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] last_res = '0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_EX(start_EX),
    .op_EX   (op_EX),
    .rs1_EX  (rs1_EX),
    .rs2_EX  (rs2_EX),
    .flush_EX(flush_EX),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h want no done", result);
      end else begin
        check(name_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  // hazard: 0 none, 1 flush during DONE state, 2 stray start during CALC
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int hazard);
    int n;
    bit seen;
    bit busy_ok;
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    op_EX = op; rs1_EX = a; rs2_EX = b; start_EX = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1 start_EX = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start_EX = 1'b0;
      flush_EX = 1'b0;
      if (done) begin
        seen = 1'b1;
        if (busy) busy_ok = 1'b0;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (hazard == 1 && n == lat - 1) flush_EX = 1'b1;
        if (hazard == 2 && n == 5) begin
          start_EX = 1'b1; op_EX = 2'b00; rs1_EX = 32'd9; rs2_EX = 32'd3;
        end
      end
    end
    if (seen) begin
      check_int({nm, "_lat"}, n, lat);
      check_int({nm, "_busy"}, int'(busy_ok), 1);
      last_res = exp;
    end else begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done at %0d", nm, lat);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic no_done_window(input string nm, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check_int(nm, int'(seen), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #10;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("div_100_7",   2'b00, 32'd100,      32'd7,          32'd14,         34, 0);
    do_op("rem_100_7",   2'b10, 32'd100,      32'd7,          32'd2,          34, 0);
    do_op("rem_m100_7",  2'b10, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFFE,   34, 0);
    do_op("div_m100_7",  2'b00, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   34, 0);
    do_op("div_100_m7",  2'b00, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   34, 0);
    do_op("rem_100_m7",  2'b10, 32'd100,      32'hFFFFFFF9,   32'd2,          34, 0);
    do_op("divu_max_2",  2'b01, 32'hFFFFFFFF, 32'd2,          32'h7FFFFFFF,   34, 0);
    do_op("remu_max_2",  2'b11, 32'hFFFFFFFF, 32'd2,          32'd1,          34, 0);
    do_op("div_m1_2",    2'b00, 32'hFFFFFFFF, 32'd2,          32'd0,          34, 0);
    do_op("rem_m1_2",    2'b10, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF,   34, 0);
    do_op("divu_min_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF,   32'd0,          34, 0);
    do_op("remu_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   34, 0);
    do_op("div_5_0",     2'b00, 32'd5,        32'd0,          32'hFFFFFFFF,   1,  0);
    do_op("divu_5_0",    2'b01, 32'd5,        32'd0,          32'hFFFFFFFF,   1,  0);
    do_op("rem_5_0",     2'b10, 32'd5,        32'd0,          32'd5,          1,  0);
    do_op("remu_min_0",  2'b11, 32'h80000000, 32'd0,          32'h80000000,   1,  0);
    do_op("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1,  0);
    do_op("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF,   32'd0,          1,  0);
    do_op("flush_in_done", 2'b01, 32'd1000,   32'd7,          32'd142,        34, 1);
    do_op("start_in_calc", 2'b01, 32'd100,    32'd7,          32'd14,         34, 2);

    // flush mid-CALC: no done, busy drops, result keeps the last value
    @(negedge clk);
    op_EX = 2'b00; rs1_EX = 32'd1000; rs2_EX = 32'd3; start_EX = 1'b1;
    @(posedge clk);
    #1 start_EX = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_EX = 1'b1;
    @(posedge clk);
    #1 flush_EX = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result", result, last_res);
    no_done_window("flush_no_done", 40);

    // flush and start together in IDLE: request dropped
    @(negedge clk);
    op_EX = 2'b01; rs1_EX = 32'd50; rs2_EX = 32'd5; start_EX = 1'b1; flush_EX = 1'b1;
    @(posedge clk);
    #1 start_EX = 1'b0; flush_EX = 1'b0;
    check("flushstart_busy", {31'd0, busy}, 32'd0);
    no_done_window("flushstart_no_done", 40);

    // asynchronous reset mid-CALC
    @(negedge clk);
    op_EX = 2'b01; rs1_EX = 32'd1000; rs2_EX = 32'd7; start_EX = 1'b1;
    @(posedge clk);
    #1 start_EX = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    no_done_window("arst_no_done", 40);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 0);

    repeat (3) @(negedge clk);
    check_int("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
